bu_req_arb: RTL and testbench
=============================

Name: bu_req_arb

Overview:
- N-channel parametrised successor to the two-port (L1-I/L1-D) bus request mux.
- Arbitrates cache-controller requests from NUM_CH L1 clients onto the single cache_bus_unit request interface.
- Fixed-priority or round-robin arbitration, whole-transaction grant locking, and a per-transaction watchdog that converts a hung bus unit into bus_error.

Parameters:
NUM_CH, 2, number of requesting channels (1..8); channel 0 has highest fixed priority
ADDR_W, 64, physical address width
DATA_W, 64, data width
CNT_W, 11, addr_count width
ARB_MODE, 0, 0 = fixed priority, 1 = round-robin
TIMEOUT_CYC, 1024, watchdog limit in cycles; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
ch_write_through_req  in  NUM_CH  per-channel single write request
ch_write_line_req  in  NUM_CH  per-channel dirty line write-back request
ch_read_req  in  NUM_CH  per-channel single read request
ch_read_line_req  in  NUM_CH  per-channel line refill request
ch_size  in  4*NUM_CH  per-channel size, one-hot 1/2/4/8 bytes
ch_pa  in  ADDR_W*NUM_CH  per-channel physical address
ch_wt_data  in  DATA_W*NUM_CH  per-channel write data
ch_line_data  out  DATA_W  line data broadcast to all channels
ch_addr_count  out  CNT_W  addr_count broadcast to all channels
ch_line_write  out  NUM_CH  cache write strobe, granted channel only
ch_cache_entry_write  out  NUM_CH  entry update strobe, granted channel only
ch_trans_rdy  out  NUM_CH  transfer done, granted channel only
ch_bus_error  out  NUM_CH  access failed or timed out, granted channel only
write_through_req, write_line_req, read_req, read_line_req  out  1 each  to bus unit
size  out  4  to bus unit
pa  out  ADDR_W  to bus unit
wt_data  out  DATA_W  to bus unit
line_data  in  DATA_W  from bus unit
addr_count  in  CNT_W  from bus unit
line_write, cache_entry_write, trans_rdy, bus_error  in  1 each  from bus unit
grant_valid  out  1  a channel is granted (BUSY)
grant_id  out  3  index of the granted channel
timeout_pulse  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (rst == 0 at a clk edge): state = IDLE, rr_ptr = 0, wdog = 0. All outputs are 0 in IDLE and RELEASE except the ch_line_data/ch_addr_count passthrough.
- ch_any[i] = OR of channel i's four request bits.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - If any ch_any is set, latch the winner into gnt and go to BUSY.
  - Fixed mode: the winner is the lowest index.
  - Round-robin mode: the winner is the first requester at or after rr_ptr, searching upward with wrap at NUM_CH.
  - Downstream request outputs are 0 in IDLE.
  - Latency: a request sampled at edge N appears downstream from cycle N+1.
- BUSY:
  - Downstream req/size/pa/wt_data follow channel gnt combinationally.
  - Response strobes from the bus unit route combinationally to bit gnt of the ch_* vectors; all other bits are 0.
  - ch_line_data and ch_addr_count are always passed through.
  - grant_valid = 1; grant_id = gnt, zero-extended.
  - Requests from the granted channel that change mid-transaction are forwarded unchanged; the lock holds until completion.
  - Completion: trans_rdy or bus_error from the bus unit, sampled at an edge, moves the state to RELEASE.
- Watchdog:
  - wdog counts cycles while in BUSY.
  - If TIMEOUT_CYC != 0 and wdog == TIMEOUT_CYC-1 with no trans_rdy/bus_error in that cycle: assert ch_bus_error[gnt] and timeout_pulse for that cycle, then go to RELEASE.
  - wdog clears on entry to BUSY.
- RELEASE:
  - Lasts exactly 1 cycle with all downstream requests at 0, so requesters can drop their requests and the bus unit returns to idle.
  - Round-robin: rr_ptr = gnt+1, wrapping to 0 at NUM_CH.
  - Next state is IDLE. A channel still requesting is re-arbitrated there, so the minimum spacing between back-to-back grants is 3 cycles.
- Simultaneous trans_rdy and watchdog expiry: trans_rdy wins and timeout_pulse stays 0.
- Multiple request kinds set on one channel are forwarded as-is; resolving them is the bus unit's job.
- ch_size is not checked here.
- Reset asserted mid-BUSY: downstream requests drop at the next edge. The bus unit is reset by the same rst.
- NUM_CH == 1: arbitration is trivial and rr_ptr stays 0.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with all requests high -> all downstream requests = 0, grant_valid = 0, ch_trans_rdy = 0 during reset.
- Single read_line: ch0 read_line_req, pa = 0x8000_0040 -> read_line_req = 1 and pa = 0x8000_0040 from the next cycle; 8 line_write pulses appear only on ch_line_write[0]; after trans_rdy, a 1-cycle RELEASE, then IDLE.
- Fixed priority, NUM_CH = 4: ch1 and ch3 request together and keep requesting -> grant_id = 1 first; ch3 is granted only after ch1 drops.
- Round-robin, NUM_CH = 4: ch0..3 request continuously -> grant sequence 0,1,2,3,0 with a 3-cycle minimum gap between grants.
- Watchdog, TIMEOUT_CYC = 16: the bus unit never responds -> ch_bus_error[gnt] and timeout_pulse high exactly in the 16th BUSY cycle; downstream requests low the following cycle.
- Collision: trans_rdy arrives in the same cycle as watchdog expiry -> ch_trans_rdy = 1, timeout_pulse = 0, ch_bus_error = 0.

Source files
------------

// File: rtl/bu_req_arb.sv
// bu_req_arb: N-channel arbiter that multiplexes L1 cache-controller requests
// onto the single cache_bus_unit request interface. A granted channel owns the
// bus for a whole transaction; a watchdog turns a hung bus unit into bus_error.
module bu_req_arb #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int CNT_W       = 11,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  // Client side
  input  logic [NUM_CH-1:0]          ch_write_through_req,
  input  logic [NUM_CH-1:0]          ch_write_line_req,
  input  logic [NUM_CH-1:0]          ch_read_req,
  input  logic [NUM_CH-1:0]          ch_read_line_req,
  input  logic [4*NUM_CH-1:0]        ch_size,
  input  logic [ADDR_W*NUM_CH-1:0]   ch_pa,
  input  logic [DATA_W*NUM_CH-1:0]   ch_wt_data,
  output logic [DATA_W-1:0]          ch_line_data,
  output logic [CNT_W-1:0]           ch_addr_count,
  output logic [NUM_CH-1:0]          ch_line_write,
  output logic [NUM_CH-1:0]          ch_cache_entry_write,
  output logic [NUM_CH-1:0]          ch_trans_rdy,
  output logic [NUM_CH-1:0]          ch_bus_error,
  // Bus unit side
  output logic                       write_through_req,
  output logic                       write_line_req,
  output logic                       read_req,
  output logic                       read_line_req,
  output logic [3:0]                 size,
  output logic [ADDR_W-1:0]          pa,
  output logic [DATA_W-1:0]          wt_data,
  input  logic [DATA_W-1:0]          line_data,
  input  logic [CNT_W-1:0]           addr_count,
  input  logic                       line_write,
  input  logic                       cache_entry_write,
  input  logic                       trans_rdy,
  input  logic                       bus_error,
  // Status
  output logic                       grant_valid,
  output logic [2:0]                 grant_id,
  output logic                       timeout_pulse
);

  localparam int GNT_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WDOG_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int WDOG_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [WDOG_W-1:0] WDOG_LAST_V = WDOG_W'(WDOG_LAST);
  localparam logic [GNT_W-1:0]  LAST_CH     = GNT_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [GNT_W-1:0]    gnt_q, gnt_d;
  logic [GNT_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;

  logic [NUM_CH-1:0]   ch_any;
  logic                win_valid;
  logic [GNT_W-1:0]    win_id;
  logic                done;
  logic                wdog_expire;

  // Response data is shared by all clients; only the strobes are steered.
  assign ch_line_data  = line_data;
  assign ch_addr_count = addr_count;

  // A channel wants the bus if any of its four request kinds is set.
  assign ch_any = ch_write_through_req | ch_write_line_req |
                  ch_read_req          | ch_read_line_req;

  // The bus unit finishes a transaction with either trans_rdy or bus_error.
  assign done = trans_rdy | bus_error;

  // Watchdog fires on the last allowed BUSY cycle unless the bus unit answers
  // in that same cycle, so a real completion always beats the timeout.
  assign wdog_expire = (TIMEOUT_CYC != 0) && (state_q == BUSY) &&
                       (wdog_q == WDOG_LAST_V) && !done;

  // Pick the winner among requesting channels (fixed or round-robin).
  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    win_valid = 1'b0;
    win_id    = '0;
    if (ARB_MODE == 0) begin
      // Scan downward so the lowest requesting index is assigned last.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (ch_any[i]) begin
          win_valid = 1'b1;
          win_id    = GNT_W'(i);
        end
      end
    end else begin
      // Offsets scanned downward so the smallest offset from rr_ptr wins;
      // the index wraps at NUM_CH.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        int idx;
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (ch_any[idx]) begin
          win_valid = 1'b1;
          win_id    = GNT_W'(idx);
        end
      end
    end
  end

  // Next-state logic for the grant FSM, watchdog and round-robin pointer.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    wdog_d   = wdog_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = BUSY;
          gnt_d   = win_id;
          wdog_d  = '0;
        end
      end
      BUSY: begin
        if (done || wdog_expire) begin
          state_d = RELEASE;
        end else if (TIMEOUT_CYC != 0) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RELEASE: begin
        // One dead cycle lets requesters drop and the bus unit go idle.
        state_d = IDLE;
        if ((ARB_MODE != 0) && (NUM_CH > 1)) begin
          rr_ptr_d = (gnt_q == LAST_CH) ? '0 : gnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      wdog_q   <= wdog_d;
    end
  end

  // Request mux toward the bus unit and strobe demux back to the granted channel.
  always_comb begin
    write_through_req    = 1'b0;
    write_line_req       = 1'b0;
    read_req             = 1'b0;
    read_line_req        = 1'b0;
    size                 = '0;
    pa                   = '0;
    wt_data              = '0;
    ch_line_write        = '0;
    ch_cache_entry_write = '0;
    ch_trans_rdy         = '0;
    ch_bus_error         = '0;
    grant_valid          = 1'b0;
    grant_id             = '0;
    timeout_pulse        = 1'b0;
    if (state_q == BUSY) begin
      // Requests are forwarded as-is, even if they change mid-transaction.
      write_through_req           = ch_write_through_req[gnt_q];
      write_line_req              = ch_write_line_req[gnt_q];
      read_req                    = ch_read_req[gnt_q];
      read_line_req               = ch_read_line_req[gnt_q];
      size                        = ch_size[gnt_q*4 +: 4];
      pa                          = ch_pa[gnt_q*ADDR_W +: ADDR_W];
      wt_data                     = ch_wt_data[gnt_q*DATA_W +: DATA_W];
      ch_line_write[gnt_q]        = line_write;
      ch_cache_entry_write[gnt_q] = cache_entry_write;
      ch_trans_rdy[gnt_q]         = trans_rdy;
      ch_bus_error[gnt_q]         = bus_error | wdog_expire;
      grant_valid                 = 1'b1;
      grant_id                    = 3'(gnt_q);
      timeout_pulse               = wdog_expire;
    end
  end

endmodule

// File: tb/tb_bu_req_arb.sv
// Directed testbench for bu_req_arb: a fixed-priority and a round-robin
// instance (4 channels, 16-cycle watchdog) share the same stimulus.
module tb_bu_req_arb;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int CW = 11;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      ch_wt_req, ch_wl_req, ch_rd_req, ch_rl_req;
  logic [4*N-1:0]    ch_size;
  logic [AW*N-1:0]   ch_pa;
  logic [DW*N-1:0]   ch_wt_data;
  logic [DW-1:0]     line_data;
  logic [CW-1:0]     addr_count;
  logic              line_write, cache_entry_write, trans_rdy, bus_error;

  // Fixed-priority instance outputs
  logic [DW-1:0]     f_ch_line_data;
  logic [CW-1:0]     f_ch_addr_count;
  logic [N-1:0]      f_ch_line_write, f_ch_cache_entry_write, f_ch_trans_rdy, f_ch_bus_error;
  logic              f_wt_req, f_wl_req, f_rd_req, f_rl_req;
  logic [3:0]        f_size;
  logic [AW-1:0]     f_pa;
  logic [DW-1:0]     f_wt_data;
  logic              f_grant_valid;
  logic [2:0]        f_grant_id;
  logic              f_timeout;

  // Round-robin instance outputs
  logic [DW-1:0]     r_ch_line_data;
  logic [CW-1:0]     r_ch_addr_count;
  logic [N-1:0]      r_ch_line_write, r_ch_cache_entry_write, r_ch_trans_rdy, r_ch_bus_error;
  logic              r_wt_req, r_wl_req, r_rd_req, r_rl_req;
  logic [3:0]        r_size;
  logic [AW-1:0]     r_pa;
  logic [DW-1:0]     r_wt_data;
  logic              r_grant_valid;
  logic [2:0]        r_grant_id;
  logic              r_timeout;

  int checks = 0;
  int errors = 0;

  bu_req_arb #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW),
               .ARB_MODE(0), .TIMEOUT_CYC(TO)) u_fix (
    .clk(clk), .rst(rst),
    .ch_write_through_req(ch_wt_req), .ch_write_line_req(ch_wl_req),
    .ch_read_req(ch_rd_req), .ch_read_line_req(ch_rl_req),
    .ch_size(ch_size), .ch_pa(ch_pa), .ch_wt_data(ch_wt_data),
    .ch_line_data(f_ch_line_data), .ch_addr_count(f_ch_addr_count),
    .ch_line_write(f_ch_line_write), .ch_cache_entry_write(f_ch_cache_entry_write),
    .ch_trans_rdy(f_ch_trans_rdy), .ch_bus_error(f_ch_bus_error),
    .write_through_req(f_wt_req), .write_line_req(f_wl_req),
    .read_req(f_rd_req), .read_line_req(f_rl_req),
    .size(f_size), .pa(f_pa), .wt_data(f_wt_data),
    .line_data(line_data), .addr_count(addr_count),
    .line_write(line_write), .cache_entry_write(cache_entry_write),
    .trans_rdy(trans_rdy), .bus_error(bus_error),
    .grant_valid(f_grant_valid), .grant_id(f_grant_id), .timeout_pulse(f_timeout)
  );

  bu_req_arb #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW),
               .ARB_MODE(1), .TIMEOUT_CYC(TO)) u_rr (
    .clk(clk), .rst(rst),
    .ch_write_through_req(ch_wt_req), .ch_write_line_req(ch_wl_req),
    .ch_read_req(ch_rd_req), .ch_read_line_req(ch_rl_req),
    .ch_size(ch_size), .ch_pa(ch_pa), .ch_wt_data(ch_wt_data),
    .ch_line_data(r_ch_line_data), .ch_addr_count(r_ch_addr_count),
    .ch_line_write(r_ch_line_write), .ch_cache_entry_write(r_ch_cache_entry_write),
    .ch_trans_rdy(r_ch_trans_rdy), .ch_bus_error(r_ch_bus_error),
    .write_through_req(r_wt_req), .write_line_req(r_wl_req),
    .read_req(r_rd_req), .read_line_req(r_rl_req),
    .size(r_size), .pa(r_pa), .wt_data(r_wt_data),
    .line_data(line_data), .addr_count(addr_count),
    .line_write(line_write), .cache_entry_write(cache_entry_write),
    .trans_rdy(trans_rdy), .bus_error(bus_error),
    .grant_valid(r_grant_valid), .grant_id(r_grant_id), .timeout_pulse(r_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ch_wt_req = '0; ch_wl_req = '0; ch_rd_req = '0; ch_rl_req = '0;
    ch_size = '0; ch_pa = '0; ch_wt_data = '0;
    line_data = '0; addr_count = '0;
    line_write = 1'b0; cache_entry_write = 1'b0; trans_rdy = 1'b0; bus_error = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ch_wt_req = '1; ch_wl_req = '1; ch_rd_req = '1; ch_rl_req = '1;
    ch_size = '1; ch_pa = '1; ch_wt_data = '1;
    trans_rdy = 1'b1; line_write = 1'b1;
    line_data = 64'hDEAD_BEEF_0123_4567;
    addr_count = 11'h5A5;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({f_wt_req, f_wl_req, f_rd_req, f_rl_req} !== 4'b0000) begin
        errors++; $display("FAIL rst_fix_reqs: got %b expected 0000", {f_wt_req, f_wl_req, f_rd_req, f_rl_req});
      end
      checks++;
      if ({r_wt_req, r_wl_req, r_rd_req, r_rl_req} !== 4'b0000) begin
        errors++; $display("FAIL rst_rr_reqs: got %b expected 0000", {r_wt_req, r_wl_req, r_rd_req, r_rl_req});
      end
      checks++;
      if (f_grant_valid !== 1'b0) begin
        errors++; $display("FAIL rst_grant_valid: got %b expected 0", f_grant_valid);
      end
      checks++;
      if (f_ch_trans_rdy !== 4'b0000) begin
        errors++; $display("FAIL rst_ch_trans_rdy: got %b expected 0000", f_ch_trans_rdy);
      end
      checks++;
      if (f_pa !== 64'h0) begin
        errors++; $display("FAIL rst_pa: got %h expected 0", f_pa);
      end
    end
    checks++;
    if (f_ch_line_data !== 64'hDEAD_BEEF_0123_4567) begin
      errors++; $display("FAIL rst_line_data_pass: got %h expected deadbeef01234567", f_ch_line_data);
    end
    checks++;
    if (f_ch_addr_count !== 11'h5A5) begin
      errors++; $display("FAIL rst_addr_count_pass: got %h expected 5a5", f_ch_addr_count);
    end
    clear_inputs();
    rst = 1'b1;
    tick();
    checks++;
    if (f_grant_valid !== 1'b0) begin
      errors++; $display("FAIL rst_idle_after: got %b expected 0", f_grant_valid);
    end
  endtask

  task automatic test_single_read_line();
    do_reset();
    ch_rl_req[0] = 1'b1;
    ch_pa[0 +: AW] = 64'h8000_0040;
    ch_size[0 +: 4] = 4'b1000;
    tick();
    checks++;
    if (f_rl_req !== 1'b1 || f_grant_valid !== 1'b1 || f_grant_id !== 3'd0) begin
      errors++; $display("FAIL rl_grant: got req=%b gv=%b id=%0d expected 1 1 0", f_rl_req, f_grant_valid, f_grant_id);
    end
    checks++;
    if (f_pa !== 64'h8000_0040 || f_size !== 4'b1000) begin
      errors++; $display("FAIL rl_pa_size: got pa=%h size=%b expected 80000040 1000", f_pa, f_size);
    end
    for (int k = 0; k < 8; k++) begin
      line_write = 1'b1;
      addr_count = 11'(k);
      line_data = 64'hA5A5_0000_0000_0000 | 64'(k);
      #1;
      checks++;
      if (f_ch_line_write !== 4'b0001) begin
        errors++; $display("FAIL rl_line_write_%0d: got %b expected 0001", k, f_ch_line_write);
      end
      checks++;
      if (f_ch_addr_count !== 11'(k)) begin
        errors++; $display("FAIL rl_addr_count_%0d: got %0d expected %0d", k, f_ch_addr_count, k);
      end
      tick();
    end
    line_write = 1'b0;
    trans_rdy = 1'b1;
    cache_entry_write = 1'b1;
    #1;
    checks++;
    if (f_ch_trans_rdy !== 4'b0001 || f_ch_cache_entry_write !== 4'b0001) begin
      errors++; $display("FAIL rl_done_strobes: got rdy=%b cew=%b expected 0001 0001", f_ch_trans_rdy, f_ch_cache_entry_write);
    end
    tick();
    trans_rdy = 1'b0;
    cache_entry_write = 1'b0;
    #1;
    checks++;
    if (f_rl_req !== 1'b0 || f_grant_valid !== 1'b0 || f_pa !== 64'h0) begin
      errors++; $display("FAIL rl_release: got req=%b gv=%b pa=%h expected 0 0 0", f_rl_req, f_grant_valid, f_pa);
    end
    ch_rl_req = '0;
    tick();
    checks++;
    if (f_grant_valid !== 1'b0) begin
      errors++; $display("FAIL rl_idle: got %b expected 0", f_grant_valid);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    ch_rd_req = 4'b1010;
    ch_pa[1*AW +: AW] = 64'h1111;
    ch_pa[3*AW +: AW] = 64'h3333;
    tick();
    checks++;
    if (f_grant_valid !== 1'b1 || f_grant_id !== 3'd1 || f_pa !== 64'h1111) begin
      errors++; $display("FAIL fp_first: got gv=%b id=%0d pa=%h expected 1 1 1111", f_grant_valid, f_grant_id, f_pa);
    end
    trans_rdy = 1'b1;
    tick();
    trans_rdy = 1'b0;
    #1;
    checks++;
    if (f_grant_valid !== 1'b0) begin
      errors++; $display("FAIL fp_release: got %b expected 0", f_grant_valid);
    end
    tick();
    checks++;
    if (f_grant_valid !== 1'b0) begin
      errors++; $display("FAIL fp_idle: got %b expected 0", f_grant_valid);
    end
    tick();
    checks++;
    if (f_grant_valid !== 1'b1 || f_grant_id !== 3'd1) begin
      errors++; $display("FAIL fp_regrant: got gv=%b id=%0d expected 1 1", f_grant_valid, f_grant_id);
    end
    ch_rd_req[1] = 1'b0;
    #1;
    checks++;
    if (f_rd_req !== 1'b0 || f_grant_id !== 3'd1) begin
      errors++; $display("FAIL fp_lock: got req=%b id=%0d expected 0 1", f_rd_req, f_grant_id);
    end
    trans_rdy = 1'b1;
    tick();
    trans_rdy = 1'b0;
    tick();
    tick();
    checks++;
    if (f_grant_valid !== 1'b1 || f_grant_id !== 3'd3 || f_pa !== 64'h3333 || f_rd_req !== 1'b1) begin
      errors++; $display("FAIL fp_second: got gv=%b id=%0d pa=%h req=%b expected 1 3 3333 1", f_grant_valid, f_grant_id, f_pa, f_rd_req);
    end
    trans_rdy = 1'b1;
    tick();
    trans_rdy = 1'b0;
    ch_rd_req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    ch_rd_req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (r_grant_valid !== 1'b1 || r_grant_id !== 3'(g % 4)) begin
        errors++; $display("FAIL rr_grant_%0d: got gv=%b id=%0d expected 1 %0d", g, r_grant_valid, r_grant_id, g % 4);
      end
      checks++;
      if (f_grant_valid !== 1'b1 || f_grant_id !== 3'd0) begin
        errors++; $display("FAIL rr_fixed_ref_%0d: got gv=%b id=%0d expected 1 0", g, f_grant_valid, f_grant_id);
      end
      if (g == 4) ch_rd_req = 4'b0001;
      trans_rdy = 1'b1;
      tick();
      trans_rdy = 1'b0;
      #1;
      checks++;
      if (r_grant_valid !== 1'b0) begin
        errors++; $display("FAIL rr_gap_release_%0d: got %b expected 0", g, r_grant_valid);
      end
      tick();
      checks++;
      if (r_grant_valid !== 1'b0) begin
        errors++; $display("FAIL rr_gap_idle_%0d: got %b expected 0", g, r_grant_valid);
      end
      tick();
    end
    // Pointer is now 1 and only channel 0 requests: the search must wrap.
    checks++;
    if (r_grant_valid !== 1'b1 || r_grant_id !== 3'd0) begin
      errors++; $display("FAIL rr_wrap_search: got gv=%b id=%0d expected 1 0", r_grant_valid, r_grant_id);
    end
    trans_rdy = 1'b1;
    tick();
    trans_rdy = 1'b0;
    ch_rd_req = '0;
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    ch_wt_req[2] = 1'b1;
    ch_pa[2*AW +: AW] = 64'h2222;
    tick();
    for (int c = 1; c < TO; c++) begin
      checks++;
      if (f_timeout !== 1'b0 || f_ch_bus_error !== 4'b0000) begin
        errors++; $display("FAIL wd_early_%0d: got tp=%b err=%b expected 0 0000", c, f_timeout, f_ch_bus_error);
      end
      tick();
    end
    checks++;
    if (f_timeout !== 1'b1 || f_ch_bus_error !== 4'b0100 || f_wt_req !== 1'b1) begin
      errors++; $display("FAIL wd_expire: got tp=%b err=%b req=%b expected 1 0100 1", f_timeout, f_ch_bus_error, f_wt_req);
    end
    tick();
    checks++;
    if (f_wt_req !== 1'b0 || f_timeout !== 1'b0 || f_grant_valid !== 1'b0) begin
      errors++; $display("FAIL wd_release: got req=%b tp=%b gv=%b expected 0 0 0", f_wt_req, f_timeout, f_grant_valid);
    end
    ch_wt_req = '0;
    tick();
  endtask

  task automatic test_collision();
    do_reset();
    ch_rd_req[0] = 1'b1;
    tick();
    for (int c = 1; c < TO; c++) tick();
    trans_rdy = 1'b1;
    #1;
    checks++;
    if (f_ch_trans_rdy !== 4'b0001 || f_timeout !== 1'b0 || f_ch_bus_error !== 4'b0000) begin
      errors++; $display("FAIL col_rdy_wins: got rdy=%b tp=%b err=%b expected 0001 0 0000", f_ch_trans_rdy, f_timeout, f_ch_bus_error);
    end
    tick();
    trans_rdy = 1'b0;
    ch_rd_req = '0;
    #1;
    checks++;
    if (f_grant_valid !== 1'b0) begin
      errors++; $display("FAIL col_release: got %b expected 0", f_grant_valid);
    end
    tick();
  endtask

  task automatic test_bus_error();
    do_reset();
    ch_rl_req[3] = 1'b1;
    tick();
    bus_error = 1'b1;
    #1;
    checks++;
    if (f_ch_bus_error !== 4'b1000 || f_timeout !== 1'b0 || f_ch_trans_rdy !== 4'b0000) begin
      errors++; $display("FAIL be_route: got err=%b tp=%b rdy=%b expected 1000 0 0000", f_ch_bus_error, f_timeout, f_ch_trans_rdy);
    end
    tick();
    bus_error = 1'b0;
    #1;
    checks++;
    if (f_grant_valid !== 1'b0 || f_rl_req !== 1'b0) begin
      errors++; $display("FAIL be_release: got gv=%b req=%b expected 0 0", f_grant_valid, f_rl_req);
    end
    ch_rl_req = '0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    ch_wl_req[1] = 1'b1;
    tick();
    checks++;
    if (f_wl_req !== 1'b1) begin
      errors++; $display("FAIL mid_rst_busy: got %b expected 1", f_wl_req);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (f_wl_req !== 1'b0 || f_grant_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_drop: got req=%b gv=%b expected 0 0", f_wl_req, f_grant_valid);
    end
    clear_inputs();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read_line();
    test_fixed_priority();
    test_round_robin();
    test_watchdog();
    test_collision();
    test_bus_error();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

endmodule
